// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract unit. Each stage resolves one CHUNK-bit slice of the carry
// chain. A global stall freezes every stage while the output is held.
module adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("adder_pipe: WIDTH must be a multiple of CHUNK");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign b_eff    = sub ? ~b : b;

  // Stage s holds result chunks 0..s and the operand chunks still to be added.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned Rem = WIDTH - s * CHUNK;
    localparam int unsigned Lo  = s * CHUNK;

    logic [Rem-1:0]      a_in, b_in;
    logic                c_in, v_in;
    logic [CHUNK:0]      sum;
    logic [Lo+CHUNK-1:0] res_d, res_q;
    logic                c_q, v_q;

    if (s == 0) begin : g_src
      // carry_in is an inverted borrow in subtract mode, so it feeds bit 0 unchanged.
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = carry_in;
      assign v_in  = in_valid;
      assign res_d = sum[CHUNK-1:0];
    end else begin : g_src
      assign a_in  = g_stage[s-1].g_hold.a_q;
      assign b_in  = g_stage[s-1].g_hold.b_q;
      assign c_in  = g_stage[s-1].c_q;
      assign v_in  = g_stage[s-1].v_q;
      assign res_d = {sum[CHUNK-1:0], g_stage[s-1].res_q};
    end

    assign sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (!stall) begin
        res_q <= res_d;
        c_q   <= sum[CHUNK];
        v_q   <= v_in;
      end
    end

    if (s < STAGES - 1) begin : g_hold
      logic [Rem-CHUNK-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[Rem-1:CHUNK];
          b_q <= b_in[Rem-1:CHUNK];
        end
      end
    end else begin : g_last
      // The top chunk still carries a[W-1] and b_eff[W-1], so overflow is resolved here.
      logic ovf_d, ovf_q;

      assign ovf_d = (a_in[Rem-1] == b_in[Rem-1]) && (sum[CHUNK-1] != a_in[Rem-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign z         = g_stage[STAGES-1].res_q;
  assign carry_out = g_stage[STAGES-1].c_q;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed vectors, latency/stall/reset sequences and a randomized
// scoreboard against an arithmetic reference model, on a 4-stage and a 1-stage instance.
module tb_adder_pipe;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         carry_in, sub;
  logic         iv0, ir0, ov0, or0, co0, of0;
  logic         iv1, ir1, ov1, or1, co1, of1;
  logic [W-1:0] z0, z1;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(ov0), .out_ready(or0), .z(z0),
    .carry_out(co0), .overflow(of0)
  );

  adder_pipe #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(ov1), .out_ready(or1), .z(z1),
    .carry_out(co1), .overflow(of1)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] z;
    logic        cout, ovf;
  } vec_t;

  vec_t        tbl[8];
  int          vecs = 0;
  int          errs = 0;
  logic [33:0] q0[$];
  logic [33:0] q1[$];

  // Reference: {overflow, carry_out, z} from integer arithmetic on the operand values.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    longint ux, uy, sx, sy, r, sr;
    logic   cout, ovf;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      r    = ux + uy + longint'(ci);
      cout = (r >>> 32) != 0;
      sr   = sx + sy + longint'(ci);
    end else begin
      r    = ux - uy - (ci ? 64'sd0 : 64'sd1);
      cout = r >= 0;
      sr   = sx - sy - (ci ? 64'sd0 : 64'sd1);
    end
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ovf, cout, r[31:0]};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov0 && or0) begin
        if (q0.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL sb0_unexpected: got result %h, expected none", z0);
        end else begin
          logic [33:0] e;
          e = q0.pop_front();
          check("sb0_result", 64'({of0, co0, z0}), 64'(e));
        end
      end
      if (iv0 && ir0) q0.push_back(model(a, b, carry_in, sub));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL sb1_unexpected: got result %h, expected none", z1);
        end else begin
          logic [33:0] e;
          e = q1.pop_front();
          check("sb1_result", 64'({of1, co1, z1}), 64'(e));
        end
      end
      if (iv1 && ir1) q1.push_back(model(a, b, carry_in, sub));
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit seen;
    @(posedge clk); #1;
    a = v.a; b = v.b; carry_in = v.cin; sub = v.sub; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0; a = $urandom; b = $urandom; carry_in = ~v.cin; sub = ~v.sub;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      if (ov0) seen = 1'b1;
      else n++;
    end
    check($sformatf("vec%0d_latency", idx), 64'(n), 64'd3);
    check($sformatf("vec%0d_z", idx), 64'(z0), 64'(v.z));
    check($sformatf("vec%0d_cout", idx), 64'(co0), 64'(v.cout));
    check($sformatf("vec%0d_ovf", idx), 64'(of0), 64'(v.ovf));
  endtask

  task automatic burst(input int which, input int st);
    logic [15:0] bits;
    bits = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        a = $urandom; b = $urandom; carry_in = 1'($urandom); sub = 1'($urandom);
      end
      if (which == 0) iv0 = (i < 8);
      else iv1 = (i < 8);
      @(negedge clk);
      bits[i] = (which == 0) ? ov0 : ov1;
    end
    check($sformatf("burst%0d_valid_pattern", which), 64'(bits), 64'(16'hFF << st));
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while ((q0.size() != 0 || ov0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain0_empty", 64'(q0.size()), 64'd0);
  endtask

  initial begin
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[5] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[7] = '{32'h12345678, 32'h0000FF88, 1'b1, 1'b0, 32'h12355601, 1'b0, 1'b0};

    rst_n = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    #2;
    check("reset_out_valid", 64'(ov0), 64'd0);
    check("reset_z", 64'(z0), 64'd0);
    check("reset_carry_out", 64'(co0), 64'd0);
    check("reset_overflow", 64'(of0), 64'd0);
    check("reset_in_ready", 64'(ir0), 64'd1);
    #5 rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], i);

    burst(0, 4);
    burst(1, 1);

    // Fill the pipe, then hold out_ready low for three cycles.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom; carry_in = 1'($urandom); sub = 1'($urandom); iv0 = 1'b1;
    end
    @(posedge clk); #1;
    a = $urandom; b = $urandom; or0 = 1'b0;
    begin
      logic [W-1:0] hz;
      @(negedge clk);
      hz = z0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("stall%0d_in_ready", k), 64'(ir0), 64'd0);
        check($sformatf("stall%0d_out_valid", k), 64'(ov0), 64'd1);
        check($sformatf("stall%0d_z_stable", k), 64'(z0), 64'(hz));
      end
    end
    @(posedge clk); #1;
    or0 = 1'b1; iv0 = 1'b0;
    drain0();

    // Random valid/ready traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom; carry_in = 1'($urandom); sub = 1'($urandom);
      if ($urandom_range(3) == 0) a = 32'hFFFFFFFF;
      iv0 = ($urandom_range(3) != 0);
      or0 = ($urandom_range(2) != 0);
    end
    @(posedge clk); #1;
    iv0 = 1'b0; or0 = 1'b1;
    drain0();

    // Two operations in flight, then an asynchronous reset pulse between edges.
    @(posedge clk); #1;
    a = $urandom; b = $urandom; iv0 = 1'b1;
    @(posedge clk); #1;
    a = $urandom; b = $urandom;
    @(posedge clk); #1;
    iv0 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(ov0), 64'd0);
    check("midreset_z", 64'(z0), 64'd0);
    check("midreset_in_ready", 64'(ir0), 64'd1);
    q0.delete();
    #1 rst_n = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (ov0) stale++;
      end
      check("midreset_no_stale", 64'(stale), 64'd0);
    end
    run_vec(tbl[1], 8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
